// File: rtl/rom_stream_loader_if.sv
// Signal bundle between the ROM stream loader (master) and its environment:
// command byte stream in, read-back byte stream out, and the lookup-memory port.
interface rom_stream_loader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              cmd_err;

    modport master (
        input  in_data, in_valid, out_ready, mem_rdata,
        output in_ready, out_data, out_valid, mem_addr, mem_wdata, mem_we, busy, cmd_err
    );

    modport slave (
        output in_data, in_valid, out_ready, mem_rdata,
        input  in_ready, out_data, out_valid, mem_addr, mem_wdata, mem_we, busy, cmd_err
    );
endinterface

// File: rtl/rom_stream_loader.sv
// Byte-stream command engine that loads and reads back the lookup memory.
// Frames: CMD, ADDR_H, ADDR_L, LEN_H, LEN_L, then LEN data bytes for writes.
module rom_stream_loader #(
    parameter int DEPTH  = 768,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input logic                 clk,
    input logic                 rst,
    rom_stream_loader_if.master bus
);
    localparam int                HI_W       = ADDR_W - DATA_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(DEPTH);
    localparam logic [DATA_W-1:0] CMD_WRITE  = DATA_W'(8'h57);
    localparam logic [DATA_W-1:0] CMD_READ   = DATA_W'(8'h52);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_H,
        ADDR_L,
        LEN_H,
        LEN_L,
        WDATA,
        RDATA
    } state_t;

    state_t            r_state, w_stateNext;
    logic              r_isWrite, w_isWriteNext;
    logic              r_suppress, w_suppressNext;
    logic [HI_W-1:0]   r_addrH, w_addrHNext;
    logic [ADDR_W-1:0] r_ptr, w_ptrNext;
    logic [15:0]       r_len, w_lenNext;
    logic [DATA_W-1:0] r_outData, w_outDataNext;
    logic              r_outValid, w_outValidNext;
    logic [DATA_W-1:0] r_memWdata, w_memWdataNext;
    logic              r_memWe, w_memWeNext;
    logic              r_cmdErr, w_cmdErrNext;

    logic              w_inReady;
    logic              w_accept;
    logic              w_load;
    logic [ADDR_W-1:0] w_startAddr;
    logic              w_startBad;

    function automatic logic [ADDR_W-1:0] nextAddr(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    assign w_inReady   = !rst && (r_state != RDATA);
    assign w_accept    = bus.in_valid && w_inReady;
    assign w_load      = (r_state == RDATA) && !r_memWe && (!r_outValid || bus.out_ready);
    assign w_startAddr = {r_addrH, bus.in_data};
    assign w_startBad  = {1'b0, w_startAddr} >= ADDR_LIMIT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_isWrite  <= 1'b0;
            r_suppress <= 1'b0;
            r_addrH    <= '0;
            r_ptr      <= '0;
            r_len      <= '0;
            r_outData  <= '0;
            r_outValid <= 1'b0;
            r_memWdata <= '0;
            r_memWe    <= 1'b0;
            r_cmdErr   <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_isWrite  <= w_isWriteNext;
            r_suppress <= w_suppressNext;
            r_addrH    <= w_addrHNext;
            r_ptr      <= w_ptrNext;
            r_len      <= w_lenNext;
            r_outData  <= w_outDataNext;
            r_outValid <= w_outValidNext;
            r_memWdata <= w_memWdataNext;
            r_memWe    <= w_memWeNext;
            r_cmdErr   <= w_cmdErrNext;
        end
    end

    // Pointer advance and out_valid release happen in any state, so a final
    // write pulse or pending read-back byte can overlap the next header.
    always_comb begin
        w_stateNext    = r_state;
        w_isWriteNext  = r_isWrite;
        w_suppressNext = r_suppress;
        w_addrHNext    = r_addrH;
        w_ptrNext      = r_ptr;
        w_lenNext      = r_len;
        w_outDataNext  = r_outData;
        w_outValidNext = r_outValid;
        w_memWdataNext = r_memWdata;
        w_memWeNext    = 1'b0;
        w_cmdErrNext   = r_cmdErr;

        if (r_memWe) begin
            w_ptrNext = nextAddr(r_ptr);
        end
        if (r_outValid && bus.out_ready) begin
            w_outValidNext = 1'b0;
        end

        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (bus.in_data == CMD_WRITE) begin
                        w_isWriteNext = 1'b1;
                        w_stateNext   = ADDR_H;
                    end else if (bus.in_data == CMD_READ) begin
                        w_isWriteNext = 1'b0;
                        w_stateNext   = ADDR_H;
                    end else begin
                        w_cmdErrNext = 1'b1;
                    end
                end
            end
            ADDR_H: begin
                if (w_accept) begin
                    w_addrHNext = bus.in_data[HI_W-1:0];
                    w_stateNext = ADDR_L;
                end
            end
            ADDR_L: begin
                if (w_accept) begin
                    w_ptrNext      = w_startAddr;
                    w_suppressNext = w_startBad;
                    if (w_startBad) begin
                        w_cmdErrNext = 1'b1;
                    end
                    w_stateNext = LEN_H;
                end
            end
            LEN_H: begin
                if (w_accept) begin
                    w_lenNext   = {bus.in_data[7:0], 8'h00};
                    w_stateNext = LEN_L;
                end
            end
            LEN_L: begin
                if (w_accept) begin
                    w_lenNext = {r_len[15:8], bus.in_data[7:0]};
                    if ({r_len[15:8], bus.in_data[7:0]} == 16'd0) begin
                        w_stateNext = IDLE;
                    end else if (r_isWrite) begin
                        w_stateNext = WDATA;
                    end else begin
                        w_stateNext = RDATA;
                    end
                end
            end
            WDATA: begin
                if (w_accept) begin
                    w_memWeNext    = !r_suppress;
                    w_memWdataNext = bus.in_data;
                    w_lenNext      = r_len - 16'd1;
                    if (r_len == 16'd1) begin
                        w_stateNext = IDLE;
                    end
                end
            end
            RDATA: begin
                if (w_load) begin
                    w_outDataNext  = r_suppress ? '0 : bus.mem_rdata;
                    w_outValidNext = 1'b1;
                    w_ptrNext      = nextAddr(r_ptr);
                    w_lenNext      = r_len - 16'd1;
                    if (r_len == 16'd1) begin
                        w_stateNext = IDLE;
                    end
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_data  = r_outData;
    assign bus.out_valid = r_outValid;
    assign bus.mem_addr  = r_ptr;
    assign bus.mem_wdata = r_memWdata;
    assign bus.mem_we    = r_memWe;
    assign bus.cmd_err   = r_cmdErr;
    assign bus.busy      = (r_state != IDLE) || r_outValid || r_memWe;
endmodule

// File: tb/tb_rom_stream_loader.sv
// Scoreboard bench for rom_stream_loader: frames are modelled as whole
// memory transactions and the expected writes/read-back bytes are queued.
module tb_rom_stream_loader;
    localparam int DEPTH = 768;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rom_stream_loader_if #(.ADDR_W(10), .DATA_W(8)) bus ();

    rom_stream_loader #(.DEPTH(DEPTH), .ADDR_W(10), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
    } wr_t;

    logic [7:0] tbMem  [0:DEPTH-1];
    logic [7:0] refMem [0:DEPTH-1];
    wr_t        wrQ[$];
    logic [7:0] rdQ[$];
    logic [7:0] dataQ[$];

    int   errors = 0;
    int   checks = 0;
    bit   cmdErrExp = 0;
    bit   randReady = 0;
    bit   bpMode = 0;
    int   bpBase = 0;
    int   stallLeft = 0;
    int   readCount = 0;
    bit   prevHeld = 0;
    logic [7:0] prevData;
    logic [9:0] prevAddr;

    // Behavioural memory behind the loader: combinational read, clocked write.
    assign bus.mem_rdata = (bus.mem_addr < 10'(DEPTH)) ? tbMem[bus.mem_addr] : 8'h00;

    always @(posedge clk) begin
        if (bus.mem_we && bus.mem_addr < 10'(DEPTH)) tbMem[bus.mem_addr] = bus.mem_wdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
        end
        bus.in_valid = 1'b0;
        checkOutput("in_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic maybeGap(input bit gaps);
        if (gaps) idle($urandom_range(0, 2));
    endtask

    // One whole frame; expected effects are derived from address arithmetic
    // on the reference memory, not from the byte-level protocol.
    task automatic applyStimulus(input logic [7:0] cmd, input int addr, input int len, input bit gaps);
        bit         supp;
        int         a;
        logic [7:0] d;
        logic [7:0] payload[$];
        if (cmd != 8'h57 && cmd != 8'h52) begin
            cmdErrExp = 1'b1;
            sendByte(cmd);
            maybeGap(gaps);
            return;
        end
        supp = (addr >= DEPTH);
        if (supp) cmdErrExp = 1'b1;
        sendByte(cmd);                     maybeGap(gaps);
        sendByte(8'((addr >> 8) & 3));     maybeGap(gaps);
        sendByte(8'(addr & 255));          maybeGap(gaps);
        sendByte(8'((len >> 8) & 255));    maybeGap(gaps);
        sendByte(8'(len & 255));
        if (cmd == 8'h57) begin
            for (int i = 0; i < len; i++) begin
                d = (dataQ.size() > 0) ? dataQ.pop_front() : 8'($urandom);
                payload.push_back(d);
                if (!supp) begin
                    a = (addr + i) % DEPTH;
                    wrQ.push_back('{addr: 10'(a), data: d});
                    refMem[a] = d;
                end
            end
            for (int i = 0; i < len; i++) begin
                maybeGap(gaps);
                sendByte(payload[i]);
            end
        end else begin
            for (int i = 0; i < len; i++) begin
                rdQ.push_back(supp ? 8'h00 : refMem[(addr + i) % DEPTH]);
            end
        end
        maybeGap(gaps);
    endtask

    task automatic waitDrain();
        for (int n = 0; n < 3000; n++) begin
            if (wrQ.size() == 0 && rdQ.size() == 0 && !bus.out_valid && !bus.busy) return;
            @(posedge clk);
            #1;
        end
        checkOutput("drain_timeout", 32'(wrQ.size() + rdQ.size()), 32'd0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write pulse
    // or a read-back transfer, and checks hold behaviour under backpressure.
    always @(negedge clk) begin
        wr_t e;
        if (rst) begin
            prevHeld = 1'b0;
        end else begin
            if (prevHeld) begin
                checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
                checkOutput("hold_data", 32'(bus.out_data), 32'(prevData));
                if (bpMode) checkOutput("hold_addr", 32'(bus.mem_addr), 32'(prevAddr));
            end
            if (bus.out_valid && rdQ.size() >= 2) begin
                checkOutput("in_ready_rdata", 32'(bus.in_ready), 32'd0);
            end
            if (bus.mem_we) begin
                if (wrQ.size() == 0) begin
                    checkOutput("unexpected_write", 32'(bus.mem_addr), 32'hFFFF_FFFF);
                end else begin
                    e = wrQ.pop_front();
                    checkOutput("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                    checkOutput("wr_data", 32'(bus.mem_wdata), 32'(e.data));
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                readCount++;
                if (rdQ.size() == 0) begin
                    checkOutput("unexpected_read", 32'(bus.out_data), 32'hFFFF_FFFF);
                end else begin
                    checkOutput("rd_data", 32'(bus.out_data), 32'(rdQ.pop_front()));
                end
            end
            prevHeld = bus.out_valid && !bus.out_ready;
            prevData = bus.out_data;
            prevAddr = bus.mem_addr;
        end
    end

    // Consumer: random or scripted out_ready, updated just after each edge.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bpMode) begin
                if (readCount - bpBase == 2 && stallLeft > 0) begin
                    bus.out_ready = 1'b0;
                    stallLeft--;
                end else begin
                    bus.out_ready = 1'b1;
                end
            end else if (randReady) begin
                bus.out_ready = ($urandom_range(0, 9) < 7);
            end else begin
                bus.out_ready = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int         r, addr, len;
        logic [7:0] d1, d2;

        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            tbMem[i]  = 8'h00;
            refMem[i] = 8'h00;
        end

        #1;
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
        checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_cmd_err", 32'(bus.cmd_err), 32'd0);
        idle(3);
        rst = 1'b0;
        #1;
        checkOutput("release_in_ready", 32'(bus.in_ready), 32'd1);

        $display("[TB] write with wrap");
        dataQ = '{8'h11, 8'h22, 8'h33};
        applyStimulus(8'h57, 'h2FE, 3, 1'b0);
        checkOutput("last_pulse_we", 32'(bus.mem_we), 32'd1);
        checkOutput("last_pulse_busy", 32'(bus.busy), 32'd1);
        idle(1);
        checkOutput("busy_drop", 32'(bus.busy), 32'd0);
        waitDrain();

        $display("[TB] read-back");
        applyStimulus(8'h52, 'h2FE, 3, 1'b0);
        waitDrain();

        $display("[TB] backpressure");
        applyStimulus(8'h57, 'h100, 4, 1'b0);
        waitDrain();
        bpBase    = readCount;
        stallLeft = 5;
        bpMode    = 1'b1;
        applyStimulus(8'h52, 'h100, 4, 1'b0);
        waitDrain();
        bpMode = 1'b0;
        checkOutput("bp_count", 32'(readCount - bpBase), 32'd4);

        $display("[TB] bad command");
        applyStimulus(8'h00, 0, 0, 1'b0);
        checkOutput("cmd_err_bad", 32'(bus.cmd_err), 32'(cmdErrExp));
        dataQ = '{8'hAA};
        applyStimulus(8'h57, 'h010, 1, 1'b0);
        waitDrain();

        $display("[TB] out-of-range start");
        applyStimulus(8'h57, 'h300, 2, 1'b0);
        checkOutput("cmd_err_oor", 32'(bus.cmd_err), 32'(cmdErrExp));
        applyStimulus(8'h52, 'h3FF, 1, 1'b0);
        waitDrain();

        $display("[TB] reset mid-write");
        sendByte(8'h57);
        sendByte(8'h00);
        sendByte(8'h20);
        sendByte(8'h00);
        sendByte(8'h05);
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        wrQ.push_back('{addr: 10'h020, data: d1});
        refMem[32'h20] = d1;
        sendByte(d1);
        sendByte(d2);
        rst = 1'b1;
        cmdErrExp = 1'b0;
        #1;
        checkOutput("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("mid_rst_mem_we", 32'(bus.mem_we), 32'd0);
        checkOutput("mid_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("mid_rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        checkOutput("mid_rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("mid_rst_cmd_err", 32'(bus.cmd_err), 32'd0);
        idle(2);
        rst = 1'b0;
        #1;
        dataQ = '{8'h5A};
        applyStimulus(8'h57, 'h005, 1, 1'b0);
        waitDrain();
        checkOutput("after_rst_cmd_err", 32'(bus.cmd_err), 32'd0);

        $display("[TB] random frames");
        randReady = 1'b1;
        for (int f = 0; f < 60; f++) begin
            r    = $urandom_range(0, 9);
            addr = ($urandom_range(0, 9) < 1) ? $urandom_range(DEPTH, 1023)
                 : ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 4, DEPTH - 1)
                 : $urandom_range(0, DEPTH - 1);
            len  = $urandom_range(0, 6);
            if (r < 1) begin
                do b = 8'($urandom); while (b == 8'h57 || b == 8'h52);
            end else begin
                b = (r < 5) ? 8'h57 : 8'h52;
            end
            applyStimulus(b, addr, len, 1'b1);
            checkOutput("cmd_err_rand", 32'(bus.cmd_err), 32'(cmdErrExp));
        end
        waitDrain();
        randReady = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
